md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the E stage, directly downstream of the
//  ID/EX register. Consumes the E-stage operands (RD1_E/RD2_E after forwarding)
//  and a decoded md_op; owns the HI/LO registers. Raises busy so the hazard unit

---
 rtl/md_unit_if.sv | 22 ++
 rtl/md_unit.sv | 130 +++++++++++++
 tb/tb_md_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Operand/command and HI/LO result bundle between the E stage and the
// multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  start, md_op, src_a, src_b, flush,
        output busy, hi, lo
    );

    modport master (
        output start, md_op, src_a, src_b, flush,
        input  busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with its HI/LO registers. The result is
// computed from latched operands and written on the final counted edge.
//   state  | meaning
//   S_IDLE | no op in flight; accepts md ops, MTHI/MTLO write directly
//   S_MUL  | MULT/MULTU in flight, cnt_q edges remain
//   S_DIV  | DIV/DIVU in flight, cnt_q edges remain
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      rst_n,
    md_unit_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    logic [63:0]        ext_a, ext_b, mul_res, div_res;
    logic signed [31:0] sq, sr;

    // Sign- or zero-extending to 64 bits lets one truncated product serve both forms.
    always_comb begin
        ext_a   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        mul_res = ext_a * ext_b;
    end

    always_comb begin
        sq      = '0;
        sr      = '0;
        div_res = '0;
        if (b_q == 32'b0) begin
            div_res = {a_q, 32'hFFFF_FFFF};
        end else if (sgn_q && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            div_res = {32'b0, 32'h8000_0000};
        end else if (sgn_q) begin
            sq      = $signed(a_q) / $signed(b_q);
            sr      = $signed(a_q) % $signed(b_q);
            div_res = {sr, sq};
        end else begin
            div_res = {a_q % b_q, a_q / b_q};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (md.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md.start) begin
                        case (md.md_op)
                            3'd0, 3'd1: begin
                                state_d = S_MUL;
                                cnt_d   = CNT_W'(MULT_CYCLES);
                                sgn_d   = ~md.md_op[0];
                                a_d     = md.src_a;
                                b_d     = md.src_b;
                            end
                            3'd2, 3'd3: begin
                                state_d = S_DIV;
                                cnt_d   = CNT_W'(DIV_CYCLES);
                                sgn_d   = ~md.md_op[0];
                                a_d     = md.src_a;
                                b_d     = md.src_b;
                            end
                            3'd4:    hi_d = md.src_a;
                            3'd5:    lo_d = md.src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        if (state_q == S_MUL) {hi_d, lo_d} = mul_res;
                        else                  {hi_d, lo_d} = div_res;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = (state_q != S_IDLE) | (md.start & ~md.flush & ~md.md_op[2]);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO results are queued at issue and
// popped when the op's completion edge has passed.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic rst_n;
    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] hl_model = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        case (op)
            3'd0: begin
                p = longint'(int'(a)) * longint'(int'(b));
                return p;
            end
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = int'(a) / int'(b);
                r = int'(a) - q * int'(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue an md op, push its expected result, walk the busy window, then
    // pop and compare. With intrude set, an MTHI is presented mid-flight.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit intrude);
        int n;
        logic [63:0] got;
        n = (op[1]) ? DC : MC;
        sb.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
        #1 check({tag, "_busy_acc"}, 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1 bus.start = 1'b0; bus.src_a = ~a; bus.src_b = ~b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (intrude && i == 1) begin
                bus.start = 1'b1; bus.md_op = 3'd4; bus.src_a = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            check({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
        end
        bus.start = 1'b0;
        check({tag, "_hilo_early"}, {bus.hi, bus.lo}, hl_model);
        @(negedge clk);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            check({tag, "_hilo"}, {bus.hi, bus.lo}, got);
            hl_model = got;
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = v;
        #1 check("mt_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (op == 3'd4) hl_model[63:32] = v; else hl_model[31:0] = v;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.md_op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        #12;
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a MULT (cnt=3)
        mt(3'd4, 32'h1111_1111);
        mt(3'd5, 32'h2222_2222);
        check("pre_reset_hilo", {bus.hi, bus.lo}, hl_model);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midmul_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midmul_reset_busy", 64'(bus.busy), 64'd0);
        hl_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (MC + 1) @(negedge clk);
        check("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);

        run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'h3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b0);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'h3, {32'h0000_0002, 32'hFFFF_FFFA}, 1'b1);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op("divu",  3'd3, 32'h7, 32'h2, {32'h1, 32'h3}, 1'b1);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0);
        run_op("divu_z",  3'd3, 32'h5, 32'h0, {32'h5, 32'hFFFF_FFFF}, 1'b0);
        run_op("div_z",   3'd2, 32'hFFFF_FF00, 32'h0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rop = 3'(k);
            ra  = $urandom;
            rb  = (k == 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op("rand", rop, ra, rb, model(rop, ra, rb), 1'b0);
        end

        // MTHI/MTLO back-to-back
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd4; bus.src_a = 32'h1234;
        #1 check("mthi_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 bus.md_op = 3'd5; bus.src_a = 32'h5678;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        @(negedge clk);
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("mt_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

        // Flush a DIV at its 4th post-accept edge
        mt(3'd4, 32'hA);
        mt(3'd5, 32'hB);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, {32'hA, 32'hB});
        repeat (DC) @(negedge clk);
        check("flush_hilo_late", {bus.hi, bus.lo}, {32'hA, 32'hB});

        // start together with flush is not accepted
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd3; bus.src_a = 32'd9; bus.src_b = 32'd2; bus.flush = 1'b1;
        #1 check("sf_busy_comb", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 bus.md_op = 3'd4; bus.src_a = 32'hFFFF;
        check("sf_busy_after", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 bus.start = 1'b0; bus.flush = 1'b0;
        repeat (DC + 1) @(negedge clk);
        check("sf_hilo", {bus.hi, bus.lo}, {32'hA, 32'hB});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
